// File: rtl/divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, valid/ready on both sides.
// Result is valid BUS+1 edges after acceptance; flush aborts at any point.
module divider #(
    parameter int BUS = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           div_valid,
    output logic           div_ready,
    input  logic           div_signed,
    input  logic [BUS-1:0] div_a,
    input  logic [BUS-1:0] div_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [BUS-1:0] quotient,
    output logic [BUS-1:0] remainder
);
    localparam int CW = $clog2(BUS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [BUS-1:0] rem, dvd, dsr;
    logic           sign_q, sign_r;
    logic           accept, last;
    logic [BUS-1:0] mag_a, mag_b;
    logic [BUS:0]   shifted, trial;

    assign mag_a   = (div_signed && div_a[BUS-1]) ? -div_a : div_a;
    assign mag_b   = (div_signed && div_b[BUS-1]) ? -div_b : div_b;
    assign shifted = {rem, dvd[BUS-1]};
    assign trial   = shifted - {1'b0, dsr};
    // cnt runs BUS..1 for the iterations; the cnt==0 cycle applies the sign fix-up
    assign last    = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_ready = 1'b0;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                div_ready = 1'b1;
                if (div_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt    <= CW'(BUS);
            rem    <= '0;
            dvd    <= mag_a;
            dsr    <= mag_b;
            sign_q <= div_signed & (div_a[BUS-1] ^ div_b[BUS-1]);
            sign_r <= div_signed & div_a[BUS-1];
        end else if (state == CALC && !flush) begin
            if (!last) begin
                cnt <= cnt - CW'(1);
                if (!trial[BUS]) begin
                    rem <= trial[BUS-1:0];
                    dvd <= {dvd[BUS-2:0], 1'b1};
                end else begin
                    rem <= shifted[BUS-1:0];
                    dvd <= {dvd[BUS-2:0], 1'b0};
                end
            end else begin
                // divide-by-zero keeps the all-ones quotient uncorrected; remainder restores div_a
                quotient  <= (sign_q && dsr != '0) ? -dvd : dvd;
                remainder <= sign_r ? -rem : rem;
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed checks of divider at BUS=4 and BUS=32: results, latency, stalls, flush and reset.
module tb_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush4 = 0, vld4 = 0, sgn4 = 0, rrdy4 = 0, rdy4, rv4;
    logic [3:0]  a4 = 0, b4 = 0, q4, r4;
    logic        flush32 = 0, vld32 = 0, sgn32 = 0, rrdy32 = 0, rdy32, rv32;
    logic [31:0] a32 = 0, b32 = 0, q32, r32;

    int n_chk = 0;
    int n_pass = 0;

    divider #(.BUS(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .div_valid(vld4), .div_ready(rdy4),
        .div_signed(sgn4), .div_a(a4), .div_b(b4), .res_valid(rv4), .res_ready(rrdy4),
        .quotient(q4), .remainder(r4)
    );

    divider #(.BUS(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush32), .div_valid(vld32), .div_ready(rdy32),
        .div_signed(sgn32), .div_a(a32), .div_b(b32), .res_valid(rv32), .res_ready(rrdy32),
        .quotient(q32), .remainder(r32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("excl4", {31'b0, rdy4 & rv4}, 0);
            check("excl32", {31'b0, rdy32 & rv32}, 0);
        end
    end

    function automatic logic [31:0] rdy(input bit wide);
        return wide ? {31'b0, rdy32} : {31'b0, rdy4};
    endfunction

    function automatic logic [31:0] rv(input bit wide);
        return wide ? {31'b0, rv32} : {31'b0, rv4};
    endfunction

    // Presents one operand pair and returns after the acceptance edge; operands are then scrambled.
    task automatic issue(input bit wide, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (wide) begin vld32 = 1; sgn32 = sgn; a32 = a; b32 = b; end
        else      begin vld4 = 1; sgn4 = sgn; a4 = a[3:0]; b4 = b[3:0]; end
        tick();
        vld4 = 0; vld32 = 0;
        a4 = ~a4; b4 = ~b4; a32 = ~a32; b32 = ~b32; sgn4 = ~sgn4; sgn32 = ~sgn32;
    endtask

    task automatic run(input bit wide, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int hold, input string tag);
        int n;
        logic [31:0] q, r;
        check({tag, ".ready_in"}, rdy(wide), 1);
        issue(wide, sgn, a, b);
        n = 0;
        do begin
            tick();
            n++;
        end while (rv(wide) == 0 && n < 60);
        check({tag, ".latency"}, n, wide ? 33 : 5);
        q = wide ? q32 : {28'b0, q4};
        r = wide ? r32 : {28'b0, r4};
        check({tag, ".quot"}, q, eq);
        check({tag, ".rem"}, r, er);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_valid"}, rv(wide), 1);
            check({tag, ".hold_quot"}, wide ? q32 : {28'b0, q4}, eq);
            check({tag, ".hold_rem"}, wide ? r32 : {28'b0, r4}, er);
        end
        if (wide) rrdy32 = 1; else rrdy4 = 1;
        tick();
        rrdy4 = 0; rrdy32 = 0;
        check({tag, ".ready_out"}, rdy(wide), 1);
        check({tag, ".valid_out"}, rv(wide), 0);
    endtask

    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    initial begin
        logic [31:0] ra, rb, eq, er;
        bit rs, seen;

        tick(); tick();
        rst = 0;
        check("rst.ready4", {31'b0, rdy4}, 1);
        check("rst.valid4", {31'b0, rv4}, 0);
        check("rst.quot4", {28'b0, q4}, 0);
        check("rst.rem4", {28'b0, r4}, 0);
        check("rst.ready32", {31'b0, rdy32}, 1);
        check("rst.quot32", q32, 0);

        run(0, 0, 13, 3, 4, 1, 3, "u13/3");
        run(0, 1, 4'b1001, 2, 4'b1101, 4'b1111, 0, "s-7/2");
        run(0, 1, 7, 4'b1110, 4'b1101, 1, 0, "s7/-2");
        run(0, 0, 5, 0, 4'b1111, 4'b0101, 0, "u5/0");
        run(0, 1, 5, 0, 4'b1111, 4'b0101, 0, "s5/0");
        run(0, 1, 4'b1001, 0, 4'b1111, 4'b1001, 0, "s-7/0");
        run(0, 1, 4'b1000, 4'b1111, 4'b1000, 0, 0, "s-8/-1");
        run(0, 0, 15, 15, 1, 0, 1, "u15/15");
        run(0, 0, 2, 9, 0, 2, 0, "u2/9");

        run(1, 0, 100, 7, 14, 2, 0, "w.u100/7");
        run(1, 1, -32'sd100, 7, -32'sd14, -32'sd2, 0, "w.s-100/7");
        run(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, "w.ovf");
        run(1, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, "w.umax/1");
        run(1, 0, 32'hFFFF_FFFF, 32'h8000_0000, 1, 32'h7FFF_FFFF, 1, "w.umax/msb");

        // flush during the 10th CALC cycle
        issue(1, 0, 1000, 3);
        for (int i = 0; i < 9; i++) tick();
        flush32 = 1;
        tick();
        flush32 = 0;
        check("flush.ready", {31'b0, rdy32}, 1);
        check("flush.valid", {31'b0, rv32}, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin tick(); seen |= rv32; end
        check("flush.no_valid", {31'b0, seen}, 0);
        run(1, 0, 100, 7, 14, 2, 0, "flush.after");

        // flush together with div_valid in IDLE
        flush32 = 1; vld32 = 1; sgn32 = 0; a32 = 50; b32 = 5;
        tick();
        flush32 = 0; vld32 = 0;
        check("flushvld.ready", {31'b0, rdy32}, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin tick(); seen |= rv32; end
        check("flushvld.no_valid", {31'b0, seen}, 0);

        // reset during CALC
        issue(1, 0, 77, 5);
        for (int i = 0; i < 5; i++) tick();
        rst = 1;
        tick();
        check("rstcalc.ready", {31'b0, rdy32}, 1);
        check("rstcalc.valid", {31'b0, rv32}, 0);
        check("rstcalc.quot", q32, 0);
        check("rstcalc.rem", r32, 0);
        rst = 0;

        // reset while holding a result in DONE
        issue(1, 0, 77, 5);
        for (int i = 0; i < 34; i++) tick();
        check("rstdone.pre_valid", {31'b0, rv32}, 1);
        check("rstdone.pre_quot", q32, 15);
        rst = 1;
        tick();
        check("rstdone.ready", {31'b0, rdy32}, 1);
        check("rstdone.valid", {31'b0, rv32}, 0);
        check("rstdone.quot", q32, 0);
        check("rstdone.rem", r32, 0);
        rst = 0;

        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            if (i % 7 == 0) rb = rb >> $urandom_range(0, 31);
            model(rs, ra, rb, eq, er);
            run(1, rs, ra, rb, eq, er, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
